// File: rtl/avalon_mm_ram_agent_if.sv
// Avalon-MM read/write bus between a host and a memory agent.
// Word-wide data with byte enables; read responses are qualified by readdatavalid.
interface AvalonMmRw;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic [31:0] host_to_agent;
  logic [31:0] agent_to_host;
  logic        waitrequest;
  logic        readdatavalid;

  modport Agent (
    input  address, byteenable, read, write, host_to_agent,
    output agent_to_host, waitrequest, readdatavalid
  );

  modport Host (
    output address, byteenable, read, write, host_to_agent,
    input  agent_to_host, waitrequest, readdatavalid
  );
endinterface

// File: rtl/avalon_mm_ram_agent.sv
// Byte-writable word RAM behind an Avalon-MM agent port, with per-command
// wait states and a fixed-latency pipelined read return.
module avalon_mm_ram_agent #(
  parameter int WORDS        = 1024,
  parameter int WAIT_STATES  = 1,
  parameter int READ_LATENCY = 2
) (
  input  logic     clk,
  input  logic     reset,
  AvalonMmRw.Agent bus
);
  localparam int         IDX_W = $clog2(WORDS);
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  logic             cmd, accept, wr_acc, rd_acc;
  logic [3:0]       ws_cnt_q, ws_cnt_d;
  logic [IDX_W-1:0] idx;
  logic             unused_addr;

  logic [31:0]             mem [WORDS];
  logic [READ_LATENCY:1]   vld_pipe_q;
  logic [31:0]             dat_pipe_q [READ_LATENCY:1];

  assign idx         = bus.address[IDX_W+1:2];
  assign unused_addr = ^{bus.address[31:IDX_W+2], bus.address[1:0]};

  assign cmd             = bus.read | bus.write;
  assign bus.waitrequest = cmd & (ws_cnt_q != WS);
  assign accept          = cmd & ~bus.waitrequest;
  assign wr_acc          = accept & bus.write;
  // A simultaneous read+write is a host error: the read half is dropped.
  assign rd_acc          = accept & bus.read & ~bus.write;

  always_comb begin
    ws_cnt_d = 4'd0;
    if (cmd && !accept) ws_cnt_d = ws_cnt_q + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws_cnt_q   <= 4'd0;
      vld_pipe_q <= '0;
    end else begin
      ws_cnt_q      <= ws_cnt_d;
      vld_pipe_q[1] <= rd_acc;
      for (int i = 2; i <= READ_LATENCY; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
    end
  end

  // Stage 1 samples the pre-write word, so a same-edge write never leaks in.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int b = 0; b < 4; b++)
        if (bus.byteenable[b]) mem[idx][8*b +: 8] <= bus.host_to_agent[8*b +: 8];
    end
    if (rd_acc) dat_pipe_q[1] <= mem[idx];
    for (int i = 2; i <= READ_LATENCY; i++) dat_pipe_q[i] <= dat_pipe_q[i-1];
  end

  assign bus.readdatavalid = vld_pipe_q[READ_LATENCY];
  assign bus.agent_to_host = vld_pipe_q[READ_LATENCY] ? dat_pipe_q[READ_LATENCY] : 32'd0;
endmodule

// File: tb/tb_avalon_mm_ram_agent.sv
// Scoreboarded bench for avalon_mm_ram_agent: three instances cover the
// default, a 16-word aliasing RAM, and a zero-wait / latency-3 configuration.
module tb_avalon_mm_ram_agent;
  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic        rd [3];
  logic        wr [3];
  logic [31:0] addr [3];
  logic [3:0]  be [3];
  logic [31:0] wdat [3];
  logic        wrq [3];
  logic        rdv [3];
  logic [31:0] rdat [3];

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t sb2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  AvalonMmRw bus_a ();
  AvalonMmRw bus_b ();
  AvalonMmRw bus_c ();

  assign bus_a.read = rd[0]; assign bus_a.write = wr[0]; assign bus_a.address = addr[0];
  assign bus_a.byteenable = be[0]; assign bus_a.host_to_agent = wdat[0];
  assign wrq[0] = bus_a.waitrequest; assign rdv[0] = bus_a.readdatavalid; assign rdat[0] = bus_a.agent_to_host;

  assign bus_b.read = rd[1]; assign bus_b.write = wr[1]; assign bus_b.address = addr[1];
  assign bus_b.byteenable = be[1]; assign bus_b.host_to_agent = wdat[1];
  assign wrq[1] = bus_b.waitrequest; assign rdv[1] = bus_b.readdatavalid; assign rdat[1] = bus_b.agent_to_host;

  assign bus_c.read = rd[2]; assign bus_c.write = wr[2]; assign bus_c.address = addr[2];
  assign bus_c.byteenable = be[2]; assign bus_c.host_to_agent = wdat[2];
  assign wrq[2] = bus_c.waitrequest; assign rdv[2] = bus_c.readdatavalid; assign rdat[2] = bus_c.agent_to_host;

  avalon_mm_ram_agent #(.WORDS(1024), .WAIT_STATES(1), .READ_LATENCY(2))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  avalon_mm_ram_agent #(.WORDS(16), .WAIT_STATES(1), .READ_LATENCY(2))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  avalon_mm_ram_agent #(.WORDS(1024), .WAIT_STATES(0), .READ_LATENCY(3))
    dut_c (.clk(clk), .reset(reset), .bus(bus_c));

  function automatic int sb_size(input int d);
    case (d)
      0:       return sb0.size();
      1:       return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  task automatic sb_push(input int d, input exp_t e);
    case (d)
      0:       sb0.push_back(e);
      1:       sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endtask

  task automatic sb_pop(input int d, output exp_t e);
    case (d)
      0:       e = sb0.pop_front();
      1:       e = sb1.pop_front();
      default: e = sb2.pop_front();
    endcase
  endtask

  // Response monitor: every readdatavalid must match the oldest expectation,
  // on exactly its due cycle; idle cycles must return zero data.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      exp_t e;
      checks++;
      if (rdv[d]) begin
        if (sb_size(d) == 0) begin
          failures++;
          $display("FAIL unexpected_rdv dut=%0d cyc=%0d data=%08h required=none", d, cyc, rdat[d]);
        end else begin
          sb_pop(d, e);
          if (rdat[d] !== e.data || cyc !== e.due) begin
            failures++;
            $display("FAIL read_resp dut=%0d got data=%08h cyc=%0d required data=%08h cyc=%0d",
                     d, rdat[d], cyc, e.data, e.due);
          end
        end
      end else if (rdat[d] !== 32'd0) begin
        failures++;
        $display("FAIL idle_data dut=%0d cyc=%0d got=%08h required=00000000", d, cyc, rdat[d]);
      end
    end
  end

  // Drives one command and holds it until accepted; leaves it asserted so a
  // following call issues back-to-back. Checks the number of stall cycles.
  task automatic cmd(input int d, input bit r, input bit w, input logic [31:0] a,
                     input logic [3:0] ben, input logic [31:0] wd,
                     input bit exp_rd, input logic [31:0] exp_data);
    int n = 0;
    int ws = (d == 2) ? 0 : 1;
    int rl = (d == 2) ? 3 : 2;
    exp_t e;
    rd[d] = r; wr[d] = w; addr[d] = a; be[d] = ben; wdat[d] = wd;
    forever begin
      @(negedge clk);
      if (!wrq[d]) break;
      n++;
      if (n > 40) break;
    end
    checks++;
    if (n !== ws) begin
      failures++;
      $display("FAIL wait_states dut=%0d addr=%08h got=%0d required=%0d", d, a, n, ws);
    end
    if (exp_rd) begin
      e.data = exp_data;
      e.due  = cyc + rl;
      sb_push(d, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int d);
    rd[d] = 1'b0; wr[d] = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; be[d] = 4'hF; wdat[d] = '0;
    end
    rd[0] = 1'b1; rd[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (wrq[0] !== 1'b1) begin
      failures++; $display("FAIL reset_wrq_ws1 got=%b required=1", wrq[0]);
    end
    checks++;
    if (wrq[2] !== 1'b0) begin
      failures++; $display("FAIL reset_wrq_ws0 got=%b required=0", wrq[2]);
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (rdv[d] !== 1'b0 || rdat[d] !== 32'd0) begin
        failures++; $display("FAIL reset_outputs dut=%0d rdv=%b data=%08h required 0/0", d, rdv[d], rdat[d]);
      end
    end
    idle(0); idle(2);
    @(posedge clk); #1;
    reset = 1'b0;
    settle(2);
  endtask

  task automatic test_write_read();
    cmd(0, 0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0, 0);
    cmd(0, 1, 0, 32'h10, 4'hF, 32'h0, 1, 32'hDEADBEEF);
    idle(0);
    settle(4);
  endtask

  task automatic test_byte_lanes();
    cmd(0, 0, 1, 32'h20, 4'hF, 32'h11223344, 0, 0);
    cmd(0, 0, 1, 32'h20, 4'b0101, 32'hAABBCCDD, 0, 0);
    cmd(0, 1, 0, 32'h20, 4'hF, 32'h0, 1, 32'h11BB33DD);
    cmd(0, 0, 1, 32'h20, 4'b0000, 32'hFFFFFFFF, 0, 0);
    cmd(0, 1, 0, 32'h20, 4'b0000, 32'h0, 1, 32'h11BB33DD);
    idle(0);
    settle(4);
  endtask

  task automatic test_alias();
    cmd(1, 0, 1, 32'h04, 4'hF, 32'h5, 0, 0);
    cmd(1, 1, 0, 32'h47, 4'hF, 32'h0, 1, 32'h5);
    cmd(1, 1, 0, 32'h1004, 4'hF, 32'h0, 1, 32'h5);
    idle(1);
    settle(4);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) cmd(2, 0, 1, 32'(4*i), 4'hF, 32'hA0 + 32'(i), 0, 0);
    for (int i = 0; i < 4; i++) cmd(2, 1, 0, 32'(4*i), 4'hF, 32'h0, 1, 32'hA0 + 32'(i));
    cmd(2, 1, 0, 32'h4, 4'hF, 32'h0, 1, 32'hA1);
    cmd(2, 0, 1, 32'h4, 4'hF, 32'hFF, 0, 0);
    cmd(2, 1, 0, 32'h4, 4'hF, 32'h0, 1, 32'hFF);
    idle(2);
    settle(5);
  endtask

  task automatic test_rw_collision();
    cmd(0, 1, 1, 32'h30, 4'hF, 32'h77, 0, 0);
    cmd(0, 1, 0, 32'h30, 4'hF, 32'h0, 1, 32'h77);
    idle(0);
    settle(4);
  endtask

  task automatic test_reset_mid();
    cmd(2, 1, 0, 32'h0, 4'hF, 32'h0, 1, 32'hA0);
    cmd(2, 1, 0, 32'h8, 4'hF, 32'h0, 1, 32'hA2);
    idle(2);
    reset = 1'b1;
    sb2.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rdv[2] !== 1'b0) begin
        failures++; $display("FAIL reset_drop cyc=%0d rdv=%b required=0", cyc, rdv[2]);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    settle(1);
    cmd(2, 1, 0, 32'h0, 4'hF, 32'h0, 1, 32'hA0);
    cmd(2, 1, 0, 32'h8, 4'hF, 32'h0, 1, 32'hA2);
    idle(2);
    settle(5);
  endtask

  task automatic test_drain();
    int n = 0;
    while ((sb0.size() + sb1.size() + sb2.size()) != 0 && n < 20) begin
      @(posedge clk); n++;
    end
    checks++;
    if ((sb0.size() + sb1.size() + sb2.size()) != 0) begin
      failures++;
      $display("FAIL drain outstanding=%0d/%0d/%0d required=0/0/0", sb0.size(), sb1.size(), sb2.size());
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_alias();
    test_back_to_back();
    test_rw_collision();
    test_reset_mid();
    test_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
